// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-back, write-allocate data cache
// sitting between the CPU MEM stage and a 256-bit line-wide data memory.
// Replacement is pseudo-LRU (1 bit per set for 2 ways, 3-bit tree for 4 ways).
// A miss freezes the pipeline through p1_stall_o until the refill completes.
//
// Optional feature macro: ASSOC_CACHE_STATS_EN
//   defined   -> adds hit_cnt_o / miss_cnt_o request counters
//   undefined -> counters and ports absent, cache behaviour identical
//
// Memory handshake: mem_enable_o is held high with a stable address, write
// flag and write data for as long as the FSM sits in WB or ALLOC; the memory
// completes the transfer with a single-cycle mem_ack_i pulse, and the enable
// drops in the cycle after that pulse. mem_ack_i outside WB/ALLOC is ignored.
module assoc_cache #(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
`ifdef ASSOC_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 5 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WB     = 2'd1;
    localparam logic [1:0] ST_ALLOC  = 2'd2;
    localparam logic [1:0] ST_REFILL = 2'd3;

    // Storage: metadata is reset, tag/data arrays are not.
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];
    logic [2:0]        plru_q   [SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0] data_mem [WAYS][SETS];

    logic [1:0]       state_q;
    logic [WAY_W-1:0] victim_q;

    // Address decomposition of the current CPU request.
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       word_sel;
    logic             unused_byte_bits;

    assign idx              = p1_addr_i[5 +: IDX_W];
    assign req_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel         = p1_addr_i[4:2];
    assign unused_byte_bits = ^p1_addr_i[1:0];

    logic [WAYS-1:0]   hit_vec;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic [2:0]        plru_next;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word;
    logic              req;
    logic              serve;
    logic              miss_idle;

    // Parallel tag compare across all ways; lowest matching way wins.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[idx][w] && (tag_mem[w][idx] == req_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit = |hit_vec;

    // Victim choice: lowest invalid way first, otherwise the PLRU pointer.
    always_comb begin
        logic [1:0] pv;
        logic       found;
        pv = 2'b00;
        if (WAYS == 2) begin
            pv = {1'b0, plru_q[idx][0]};
        end else if (WAYS == 4) begin
            pv = plru_q[idx][0] ? {1'b1, plru_q[idx][2]} : {1'b0, plru_q[idx][1]};
        end
        victim = WAY_W'(pv);
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[idx][w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    // PLRU update: make the tree point away from the way just accessed.
    always_comb begin
        logic [1:0] acc;
        acc       = 2'(hit_way);
        plru_next = plru_q[idx];
        if (WAYS == 2) begin
            plru_next[0] = ~acc[0];
        end else if (WAYS == 4) begin
            if (!acc[1]) begin
                plru_next[0] = 1'b1;
                plru_next[1] = ~acc[0];
            end else begin
                plru_next[0] = 1'b0;
                plru_next[2] = ~acc[0];
            end
        end
    end

    assign hit_line = data_mem[hit_way][idx];
    assign hit_word = hit_line[{word_sel, 5'b0} +: 32];

    // A request is serviced as a hit in IDLE, and again in REFILL once the
    // line has landed (store merges its word there).
    assign req       = p1_MemRead_i | p1_MemWrite_i;
    assign serve     = !rst_i && req && hit && (state_q == ST_IDLE || state_q == ST_REFILL);
    assign miss_idle = !rst_i && req && !hit && (state_q == ST_IDLE);

    assign p1_stall_o = !rst_i && (state_q == ST_WB || state_q == ST_ALLOC || miss_idle);
    assign p1_data_o  = (serve && p1_MemRead_i) ? hit_word : 32'd0;

    // Memory-side outputs are decoded purely from the registered FSM state.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            ST_WB: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_mem[victim_q][idx], idx, 5'b0};
                mem_data_o   = data_mem[victim_q][idx];
            end
            ST_ALLOC: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, idx, 5'b0};
            end
            default: ;
        endcase
    end

    // Miss-handling FSM; reset abandons any outstanding memory transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            victim_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_idle) begin
                        victim_q <= victim;
                        state_q  <= (valid_q[idx][victim] && dirty_q[idx][victim]) ? ST_WB : ST_ALLOC;
                    end
                end
                ST_WB:     if (mem_ack_i) state_q <= ST_ALLOC;
                ST_ALLOC:  if (mem_ack_i) state_q <= ST_REFILL;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Valid, dirty and PLRU bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (state_q == ST_ALLOC && mem_ack_i) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
            if (serve) begin
                plru_q[idx] <= plru_next;
                if (p1_MemWrite_i) dirty_q[idx][hit_way] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: refill writes a whole line, a store hit one word.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_ALLOC && mem_ack_i) begin
                data_mem[victim_q][idx] <= mem_data_i;
                tag_mem[victim_q][idx]  <= req_tag;
            end
            if (serve && p1_MemWrite_i) begin
                data_mem[hit_way][idx][{word_sel, 5'b0} +: 32] <= p1_data_i;
            end
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    // Request counters: hits serviced in IDLE, misses on leaving IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (serve && state_q == ST_IDLE) hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss_idle) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed testbench for assoc_cache (WAYS=2, SETS=16) with a behavioural
// line memory that acks four cycles after it first sees mem_enable_o.
module tb_assoc_cache;

  logic         clk;
  logic         rst_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_addr_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  assoc_cache #(.WAYS(2), .SETS(16), .ADDR_W(32), .LINE_W(256)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .p1_data_i     (p1_data_i),
    .p1_addr_i     (p1_addr_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .mem_data_o    (mem_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o)
`ifdef ASSOC_CACHE_STATS_EN
    ,
    .hit_cnt_o     (hit_cnt),
    .miss_cnt_o    (miss_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];      // expected load data, in request order
  logic [32:0] exp_mem_q[$];  // expected memory requests {write, addr}
  logic [31:0] exp_wb_q[$];   // expected word 2 of each write-back line

  // memory model
  logic [255:0] mem_model [logic [31:0]];
  bit           mem_busy;
  int           mem_cnt;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] default_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {a[15:0], 16'(k)};
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return default_line(a);
  endfunction

  // One cycle of memory behaviour, evaluated after outputs have settled.
  task automatic mem_service();
    if (mem_enable_o) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        if (exp_mem_q.size() == 0) begin
          check("unexpected_mem_req", {mem_write_o, mem_addr_o}, 33'h0);
        end else begin
          check("mem_req", {mem_write_o, mem_addr_o}, exp_mem_q.pop_front());
        end
        if (mem_write_o) begin
          if (exp_wb_q.size() == 0) check("unexpected_wb", 1'b1, 1'b0);
          else check("wb_word2", mem_data_o[95:64], exp_wb_q.pop_front());
        end
      end else begin
        mem_cnt++;
      end
      if (mem_cnt == 4) begin
        mem_ack_i = 1'b1;
        if (mem_write_o) mem_model[mem_addr_o] = mem_data_o;
        else mem_data_i = line_of(mem_addr_o);
        mem_busy = 1'b0;
      end
    end
  endtask

  // Drive one CPU request and hold it until the cache stops stalling.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input bit is_write, input bit exp_miss);
    int cyc;
    bit done;
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    p1_MemWrite_i = is_write;
    p1_MemRead_i  = !is_write;
    #1;
    check("first_cycle_stall", p1_stall_o, exp_miss);
    if (!exp_miss) check("hit_no_mem_traffic", mem_enable_o, 1'b0);
    done = 0;
    cyc  = 0;
    while (!done) begin
      mem_service();
      if (!p1_stall_o) begin
        if (!is_write) begin
          if (exp_q.size() == 0) check("unexpected_load", p1_data_o, 32'h0);
          else check("load_data", p1_data_o, exp_q.pop_front());
        end
        check("enable_low_when_serviced", mem_enable_o, 1'b0);
        done = 1;
      end
      @(posedge clk);
      #1;
      mem_ack_i = 1'b0;
      cyc++;
      if (!done && cyc > 50) begin
        check("stall_timeout", 1'b1, 1'b0);
        done = 1;
      end
    end
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  logic [255:0] l40;
  logic [31:0]  wd [8];

  initial begin
    rst_i         = 1'b1;
    p1_data_i     = '0;
    p1_addr_i     = '0;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    mem_data_i    = '0;
    mem_ack_i     = 1'b0;
    mem_busy      = 1'b0;
    mem_cnt       = 0;

    l40 = default_line(32'h40);
    l40[95:64] = 32'h1234_5678;
    mem_model[32'h40] = l40;

    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    check("rst_stall", p1_stall_o, 1'b0);
    check("rst_data", p1_data_o, 32'h0);
    check("rst_enable", mem_enable_o, 1'b0);
    check("rst_write", mem_write_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_mem_data", mem_data_o, 256'h0);

    // cold read: clean miss, refill from 0x40
    exp_mem_q.push_back({1'b0, 32'h40});
    exp_q.push_back(32'h1234_5678);
    access(32'h48, 32'h0, 1'b0, 1'b1);

    // store hit, then load it back with no memory traffic
    access(32'h48, 32'hDEAD_BEEF, 1'b1, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    access(32'h48, 32'h0, 1'b0, 1'b0);

    // same index, other tag: fills the invalid way 1
    exp_mem_q.push_back({1'b0, 32'h240});
    exp_q.push_back(32'h0240_0002);
    access(32'h248, 32'h0, 1'b0, 1'b1);

    // third tag: LRU way 0 is dirty, write back then allocate
    exp_mem_q.push_back({1'b1, 32'h40});
    exp_wb_q.push_back(32'hDEAD_BEEF);
    exp_mem_q.push_back({1'b0, 32'h440});
    exp_q.push_back(32'h0440_0002);
    access(32'h448, 32'h0, 1'b0, 1'b1);

    // 0x48 again: victim is way 1 (0x248, clean), no write-back
    exp_mem_q.push_back({1'b0, 32'h40});
    exp_q.push_back(32'hDEAD_BEEF);
    access(32'h48, 32'h0, 1'b0, 1'b1);

`ifdef ASSOC_CACHE_STATS_EN
    check("hit_cnt", hit_cnt, 32'd2);
    check("miss_cnt", miss_cnt, 32'd4);
`endif

    // reset while the FSM sits in ALLOC
    exp_mem_q.push_back({1'b0, 32'h640});
    p1_addr_i    = 32'h648;
    p1_MemRead_i = 1'b1;
    #1;
    check("alloc_path_stall", p1_stall_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      mem_service();
      @(posedge clk);
      #1;
      mem_ack_i = 1'b0;
    end
    check("in_alloc_enable", mem_enable_o, 1'b1);
    check("in_alloc_write", mem_write_o, 1'b0);
    rst_i        = 1'b1;
    p1_MemRead_i = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_enable", mem_enable_o, 1'b0);
    check("post_rst_stall", p1_stall_o, 1'b0);
    rst_i    = 1'b0;
    mem_busy = 1'b0;

    // everything invalid again: 0x48 misses, line comes from write-back data
    exp_mem_q.push_back({1'b0, 32'h40});
    exp_q.push_back(32'hDEAD_BEEF);
    access(32'h48, 32'h0, 1'b0, 1'b1);

    // random stores across the resident line, then read every word back
    for (int i = 0; i < 8; i++) begin
      wd[i] = $urandom;
      access(32'h40 + 32'(i * 4), wd[i], 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(wd[i]);
      access(32'h40 + 32'(i * 4), 32'h0, 1'b0, 1'b0);
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_mem_q_drained", 32'(exp_mem_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
